// File: rtl/sdram_aref_if.sv
// ---------------------------------------------------------------------------
// sdram_aref_if
// Bus between the auto-refresh generator, the init block and the command
// arbiter.
//
// Handshake: aref_req is raised by the generator and held until a grant is
// taken. A grant is taken on a rising edge where aref_req=1, aref_en=1 and
// the generator is idle, and that edge clears aref_req. aref_en while
// aref_req=0 is ignored. aref_busy marks the cycles in which cmd_reg,
// sdram_ba and sdram_addr own the SDRAM bus. aref_end pulses on the final
// busy cycle.
//
// Signals:
//   init_end_flag  init -> gen     level, SDRAM initialised
//   aref_en        arb  -> gen     grant
//   aref_req       gen  -> arb     refresh request
//   aref_end       gen  -> arb     last cycle of the sequence
//   aref_busy      gen  -> arb     sequence owns the bus
//   aref_overrun   gen  -> arb     sticky missed-interval flag
//   cmd_reg[3:0]   gen  -> mux     {cs_n, ras_n, cas_n, we_n}
//   sdram_ba[1:0]  gen  -> mux     bank address
//   sdram_addr[12:0] gen -> mux    row/column address (A10 = all banks)
// Modports: slave = generator side, master = init/arbiter side.
// ---------------------------------------------------------------------------
interface sdram_aref_if;
  logic        init_end_flag;
  logic        aref_en;
  logic        aref_req;
  logic        aref_end;
  logic        aref_busy;
  logic        aref_overrun;
  logic [3:0]  cmd_reg;
  logic [1:0]  sdram_ba;
  logic [12:0] sdram_addr;

  modport slave (
    input  init_end_flag, aref_en,
    output aref_req, aref_end, aref_busy, aref_overrun,
    output cmd_reg, sdram_ba, sdram_addr
  );

  modport master (
    output init_end_flag, aref_en,
    input  aref_req, aref_end, aref_busy, aref_overrun,
    input  cmd_reg, sdram_ba, sdram_addr
  );
endinterface

// File: rtl/sdram_aref.sv
// ---------------------------------------------------------------------------
// sdram_aref
// Periodic auto-refresh generator. After init completes it requests the bus
// every REF_PERIOD clocks; on grant it issues PRECHARGE-ALL, waits TRP_CLK,
// then REF_NUM times issues AUTO REFRESH followed by TRFC_CLK NOP cycles.
//
// Ports:
//   sysclk_100M   in   system clock
//   rst_n         in   asynchronous active-low reset
//   bus           slave modport of sdram_aref_if (request/grant, status,
//                 SDRAM command/bank/address)
//   o_dbg_state   out  current FSM state (encoding of state_t)
//
// Parameters: REF_PERIOD 32..1023, TRP_CLK >= 0, TRFC_CLK 1..255,
// REF_NUM 1..3.
// ---------------------------------------------------------------------------
module sdram_aref #(
  parameter int REF_PERIOD = 750,
  parameter int TRP_CLK    = 2,
  parameter int TRFC_CLK   = 7,
  parameter int REF_NUM    = 2
) (
  input  logic         sysclk_100M,
  input  logic         rst_n,
  sdram_aref_if.slave  bus,
  output logic [2:0]   o_dbg_state
);

  localparam logic [3:0]  C_NOP       = 4'b0111;
  localparam logic [3:0]  C_PRECHARGE = 4'b0010;
  localparam logic [3:0]  C_REFRESH   = 4'b0001;

  localparam logic [9:0]  C_PERIOD_LAST = 10'(REF_PERIOD - 1);
  localparam logic        C_HAS_TRP     = (TRP_CLK > 0);
  localparam logic [7:0]  C_TRP_LAST    = (TRP_CLK > 0) ? 8'(TRP_CLK - 1) : 8'd0;
  localparam logic [7:0]  C_TRFC_LAST   = (TRFC_CLK > 0) ? 8'(TRFC_CLK - 1) : 8'd0;
  // The final TRFC window is one cycle shorter: its last cycle is DONE.
  localparam logic [7:0]  C_TRFC_LAST2  = (TRFC_CLK > 1) ? 8'(TRFC_CLK - 2) : 8'd0;
  localparam logic        C_TRFC_ONE    = (TRFC_CLK == 1);
  localparam logic [1:0]  C_REF_NUM     = 2'(REF_NUM);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_TRP  = 3'd2,
    S_REF  = 3'd3,
    S_TRFC = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_wait;
  logic [7:0]  w_wait_nxt;
  logic [1:0]  r_ref_cnt;
  logic [1:0]  w_ref_nxt;
  logic [3:0]  r_cmd;
  logic [3:0]  w_cmd_nxt;
  logic        r_req;
  logic        r_end;
  logic        r_busy;
  logic        r_overrun;
  logic [9:0]  r_cnt;
  logic        w_expire;
  logic        w_grant;

  // Interval counter runs free once initialised, including during a
  // sequence, so the request cadence never drifts with grant latency.
  assign w_expire = bus.init_end_flag && (r_cnt == C_PERIOD_LAST);
  assign w_grant  = r_req && bus.aref_en && (r_state == S_IDLE);

  always_ff @(posedge sysclk_100M or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 10'd0;
    end else if (!bus.init_end_flag) begin
      r_cnt <= 10'd0;
    end else if (w_expire) begin
      r_cnt <= 10'd0;
    end else begin
      r_cnt <= r_cnt + 10'd1;
    end
  end

  // Expiry wins over a same-edge grant so the new interval stays requested.
  // Overrun: an interval expired while the previous one was still
  // outstanding (pending and not granted now, or sequence in progress).
  always_ff @(posedge sysclk_100M or negedge rst_n) begin
    if (!rst_n) begin
      r_req     <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (!bus.init_end_flag) begin
        r_req <= 1'b0;
      end else if (w_expire) begin
        r_req <= 1'b1;
      end else if (w_grant) begin
        r_req <= 1'b0;
      end
      if (w_expire && ((r_req && !w_grant) || r_busy)) begin
        r_overrun <= 1'b1;
      end
    end
  end

  // FSM state register and registered outputs (outputs follow next state so
  // the command appears in the same cycle the state is entered).
  always_ff @(posedge sysclk_100M or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_wait    <= 8'd0;
      r_ref_cnt <= 2'd0;
      r_cmd     <= C_NOP;
      r_busy    <= 1'b0;
      r_end     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_wait    <= w_wait_nxt;
      r_ref_cnt <= w_ref_nxt;
      r_cmd     <= w_cmd_nxt;
      r_busy    <= (w_state_nxt != S_IDLE);
      r_end     <= (w_state_nxt == S_DONE);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ref_nxt   = r_ref_cnt;
    w_wait_nxt  = 8'd0;
    w_cmd_nxt   = C_NOP;
    case (r_state)
      S_IDLE: begin
        if (w_grant) begin
          w_state_nxt = S_PRE;
        end
      end
      S_PRE: begin
        w_state_nxt = C_HAS_TRP ? S_TRP : S_REF;
      end
      S_TRP: begin
        if (r_wait == C_TRP_LAST) begin
          w_state_nxt = S_REF;
        end
      end
      S_REF: begin
        w_ref_nxt = r_ref_cnt + 2'd1;
        if (C_TRFC_ONE && (w_ref_nxt == C_REF_NUM)) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_TRFC;
        end
      end
      S_TRFC: begin
        if (r_ref_cnt != C_REF_NUM) begin
          if (r_wait == C_TRFC_LAST) begin
            w_state_nxt = S_REF;
          end
        end else if (r_wait == C_TRFC_LAST2) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_ref_nxt   = 2'd0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_ref_nxt   = 2'd0;
      end
    endcase

    // Wait counter restarts on every state change.
    if (w_state_nxt == r_state) begin
      w_wait_nxt = r_wait + 8'd1;
    end

    case (w_state_nxt)
      S_PRE:   w_cmd_nxt = C_PRECHARGE;
      S_REF:   w_cmd_nxt = C_REFRESH;
      default: w_cmd_nxt = C_NOP;
    endcase
  end

  assign bus.aref_req     = r_req;
  assign bus.aref_end     = r_end;
  assign bus.aref_busy    = r_busy;
  assign bus.aref_overrun = r_overrun;
  assign bus.cmd_reg      = r_cmd;
  assign bus.sdram_ba     = 2'b00;
  assign bus.sdram_addr   = 13'h0400;
  assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_sdram_aref.sv
// ---------------------------------------------------------------------------
// tb_sdram_aref
// Directed bench for sdram_aref. u_d0 uses default parameters; u_d1 uses
// REF_PERIOD=64, TRFC_CLK=4, REF_NUM=1. Edge counts are taken relative to
// the edge before init_end_flag (or rst_n) goes high.
// ---------------------------------------------------------------------------
module tb_sdram_aref;

  logic       clk;
  logic       rst_n;
  logic [2:0] dbg0;
  logic [2:0] dbg1;

  int n_checks;
  int n_fail;
  int n_edge;
  int n_ref;

  sdram_aref_if if0 ();
  sdram_aref_if if1 ();

  sdram_aref u_d0 (
    .sysclk_100M (clk),
    .rst_n       (rst_n),
    .bus         (if0),
    .o_dbg_state (dbg0)
  );

  sdram_aref #(
    .REF_PERIOD (64),
    .TRP_CLK    (2),
    .TRFC_CLK   (4),
    .REF_NUM    (1)
  ) u_d1 (
    .sysclk_100M (clk),
    .rst_n       (rst_n),
    .bus         (if1),
    .o_dbg_state (dbg1)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    n_edge++;
  endtask

  task automatic run_to(input int rel);
    while ((n_edge - n_ref) < rel) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] cmd_of(input bit sel);
    return sel ? if1.cmd_reg : if0.cmd_reg;
  endfunction

  function automatic logic busy_of(input bit sel);
    return sel ? if1.aref_busy : if0.aref_busy;
  endfunction

  function automatic logic end_of(input bit sel);
    return sel ? if1.aref_end : if0.aref_end;
  endfunction

  function automatic logic req_of(input bit sel);
    return sel ? if1.aref_req : if0.aref_req;
  endfunction

  function automatic logic [2:0] dbg_of(input bit sel);
    return sel ? dbg1 : dbg0;
  endfunction

  // Called while sampling cycle k=0 (just after the grant edge); walks the
  // sequence to k=len. r1/r2 are the REFRESH cycles (-1 = none).
  task automatic chk_seq(input string tag, input bit sel, input int len,
                         input int r1, input int r2);
    logic [3:0] exp_cmd;
    chk({tag, "_req_cleared"}, req_of(sel), 1'b0);
    for (int k = 0; k <= len; k++) begin
      if (k == 0)                  exp_cmd = 4'b0010;
      else if (k == r1 || k == r2) exp_cmd = 4'b0001;
      else                         exp_cmd = 4'b0111;
      chk($sformatf("%s_cmd_k%0d", tag, k), cmd_of(sel), exp_cmd);
      chk($sformatf("%s_busy_k%0d", tag, k), busy_of(sel), (k < len));
      chk($sformatf("%s_end_k%0d", tag, k), end_of(sel), (k == len - 1));
      if (k < len) tick();
    end
    chk({tag, "_idle_after"}, dbg_of(sel), 3'd0);
  endtask

  // Directed stimulus
  initial begin
    int bad;
    n_checks = 0;
    n_fail   = 0;
    n_edge   = 0;
    n_ref    = 0;
    rst_n    = 1'b0;
    if0.init_end_flag = 1'b0;
    if0.aref_en       = 1'b0;
    if1.init_end_flag = 1'b0;
    if1.aref_en       = 1'b0;
    repeat (3) tick();

    // Reset values
    chk("rst_cmd",     if0.cmd_reg, 4'b0111);
    chk("rst_addr",    if0.sdram_addr, 13'h0400);
    chk("rst_ba",      if0.sdram_ba, 2'b00);
    chk("rst_req",     if0.aref_req, 1'b0);
    chk("rst_end",     if0.aref_end, 1'b0);
    chk("rst_busy",    if0.aref_busy, 1'b0);
    chk("rst_overrun", if0.aref_overrun, 1'b0);
    chk("rst_state",   dbg0, 3'd0);
    rst_n = 1'b1;

    // Pre-init quiet, random grants must be ignored
    bad = 0;
    repeat (2000) begin
      if0.aref_en = 1'($urandom_range(0, 1));
      tick();
      if (if0.aref_req !== 1'b0 || if0.cmd_reg !== 4'b0111 ||
          if0.aref_busy !== 1'b0 || if0.sdram_addr !== 13'h0400) bad++;
    end
    if0.aref_en = 1'b0;
    chk("preinit_quiet_bad_cycles", bad, 0);

    // Basic refresh: first request on edge 750
    if0.init_end_flag = 1'b1;
    n_ref = n_edge;
    run_to(749);
    chk("req_before_750", if0.aref_req, 1'b0);
    tick();
    chk("req_at_750", if0.aref_req, 1'b1);
    if0.aref_en = 1'b1;
    tick();
    if0.aref_en = 1'b0;
    chk_seq("basic", 1'b0, 19, 3, 11);
    run_to(1499);
    chk("req_before_1500", if0.aref_req, 1'b0);
    tick();
    chk("req_at_1500", if0.aref_req, 1'b1);

    // Delayed grant: request held 100 cycles, no drift, no overrun
    bad = 0;
    repeat (100) begin
      tick();
      if (if0.aref_req !== 1'b1) bad++;
    end
    chk("delay_req_held_bad_cycles", bad, 0);
    if0.aref_en = 1'b1;
    tick();
    if0.aref_en = 1'b0;
    chk_seq("delayed", 1'b0, 19, 3, 11);
    chk("delayed_overrun", if0.aref_overrun, 1'b0);
    run_to(2249);
    chk("req_before_2250", if0.aref_req, 1'b0);
    tick();
    chk("req_at_2250", if0.aref_req, 1'b1);

    // Starvation: no grant until after the 3000 expiry
    run_to(2999);
    chk("starve_req_held", if0.aref_req, 1'b1);
    chk("starve_overrun_before", if0.aref_overrun, 1'b0);
    tick();
    chk("starve_overrun_set", if0.aref_overrun, 1'b1);
    chk("starve_req_still", if0.aref_req, 1'b1);
    if0.aref_en = 1'b1;
    tick();
    if0.aref_en = 1'b0;
    chk("starve_grant_pre", if0.cmd_reg, 4'b0010);
    chk("starve_grant_req_clr", if0.aref_req, 1'b0);
    chk("starve_overrun_sticky", if0.aref_overrun, 1'b1);

    // Reset at k=5 of that sequence
    repeat (5) tick();
    chk("k5_busy", if0.aref_busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_cmd",     if0.cmd_reg, 4'b0111);
    chk("midrst_busy",    if0.aref_busy, 1'b0);
    chk("midrst_overrun", if0.aref_overrun, 1'b0);
    chk("midrst_req",     if0.aref_req, 1'b0);
    chk("midrst_state",   dbg0, 3'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    n_ref = n_edge;
    run_to(749);
    chk("postrst_req_before_750", if0.aref_req, 1'b0);
    tick();
    chk("postrst_req_at_750", if0.aref_req, 1'b1);

    // Init falls with a request pending: request and counter clear
    if0.init_end_flag = 1'b0;
    tick();
    chk("initfall_req_clr", if0.aref_req, 1'b0);
    if0.init_end_flag = 1'b1;
    n_ref = n_edge;
    run_to(749);
    chk("reinit_req_before_750", if0.aref_req, 1'b0);
    tick();
    chk("reinit_req_at_750", if0.aref_req, 1'b1);

    // Parameter variant: L=8, REFRESH at k=3, end at k=7, period 64
    if1.init_end_flag = 1'b1;
    n_ref = n_edge;
    run_to(63);
    chk("var_req_before_64", if1.aref_req, 1'b0);
    tick();
    chk("var_req_at_64", if1.aref_req, 1'b1);
    if1.aref_en = 1'b1;
    tick();
    if1.aref_en = 1'b0;
    chk_seq("variant", 1'b1, 8, 3, -1);
    run_to(127);
    chk("var_req_before_128", if1.aref_req, 1'b0);
    tick();
    chk("var_req_at_128", if1.aref_req, 1'b1);
    chk("var_overrun", if1.aref_overrun, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
